// File: rtl/counter_pkg.sv
// Shared definitions for the prescaled up/down counter.
// Parameter legality checks, prescaler sizing and the load clamp.
package counter_pkg;

  localparam int unsigned WIDTH_MIN    = 2;
  localparam int unsigned WIDTH_MAX    = 32;
  localparam int unsigned PRESCALE_MIN = 1;
  localparam int unsigned PRESCALE_MAX = 65536;

  // Largest value representable in w bits.
  function automatic longint unsigned full_scale(
    input int unsigned w
  );
    return (64'd1 << w) - 64'd1;
  endfunction

  // Width of the counter itself.
  function automatic bit width_ok(input int unsigned w);
    return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
  endfunction

  // Terminal value must be nonzero and fit in the counter.
  function automatic bit max_ok(
    input int unsigned     w,
    input longint unsigned m
  );
    return (m >= 64'd1) && (m <= full_scale(w));
  endfunction

  // Number of clock enables folded into one count step.
  function automatic bit prescale_ok(input int unsigned p);
    return (p >= PRESCALE_MIN) && (p <= PRESCALE_MAX);
  endfunction

  function automatic bit params_ok(
    input int unsigned     w,
    input longint unsigned m,
    input int unsigned     p
  );
    return width_ok(w) && max_ok(w, m) && prescale_ok(p);
  endfunction

  // Prescaler register width; one bit minimum so the
  // degenerate divide-by-one case still has a real flop.
  function automatic int p_width(input int unsigned p);
    return (p > 1) ? $clog2(p) : 1;
  endfunction

  // Load values above the terminal value saturate to it.
  function automatic logic [31:0] clamp_max(
    input logic [31:0] d,
    input logic [31:0] m
  );
    return (d > m) ? m : d;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Clock-enable prescaler: one TICK every PRESCALE enabled cycles.
// CLR restarts the prescale count from zero.
module tick_divider
  import counter_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic CLK,
  input  logic RESET,
  input  logic CE,
  input  logic CLR,
  output logic TICK
);

  localparam int PW = p_width(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] ONE  = PW'(1);

  if (!prescale_ok(PRESCALE)) begin : g_bad_prescale
    $error("tick_divider: PRESCALE out of range");
  end

  logic [PW-1:0] p_q;
  logic [PW-1:0] p_d;

  // Tick on the last phase; clear beats advance, wrap after LAST.
  always_comb begin
    TICK = CE && (p_q == LAST);
    p_d  = p_q;
    if (CLR) begin
      p_d = '0;
    end else if (TICK) begin
      p_d = '0;
    end else if (CE) begin
      p_d = p_q + ONE;
    end
  end

  // Prescale phase register; reset drops any partial count.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      p_q <= '0;
    end else begin
      p_q <= p_d;
    end
  end

endmodule

// File: rtl/prescaled_counter.sv
// Loadable up/down counter stepping once per PRESCALE enables,
// wrapping modulo MAX+1 with a registered one-cycle wrap pulse.
module prescaled_counter
  import counter_pkg::*;
#(
  parameter int unsigned     WIDTH    = 26,
  parameter longint unsigned MAX      = (64'd1 << WIDTH) - 64'd1,
  parameter int unsigned     PRESCALE = 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CE,
  input  logic             UP,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] DATA,
  output logic [WIDTH-1:0] O,
  output logic             COUT
);

  if (!params_ok(WIDTH, MAX, PRESCALE)) begin : g_bad_params
    $error("prescaled_counter: illegal WIDTH/MAX/PRESCALE");
  end

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);
  localparam logic [31:0]      MAX32 = 32'(MAX);

  logic             tick;
  logic [31:0]      data32;
  logic [WIDTH-1:0] load_v;

  logic [WIDTH-1:0] o_q;
  logic [WIDTH-1:0] o_d;
  logic             cout_q;
  logic             cout_d;

  tick_divider #(
    .PRESCALE (PRESCALE)
  ) u_div (
    .CLK   (CLK),
    .RESET (RESET),
    .CE    (CE),
    .CLR   (LOAD),
    .TICK  (tick)
  );

  // Saturate the load value to the terminal count.
  always_comb begin
    data32 = 32'(DATA);
    load_v = WIDTH'(clamp_max(data32, MAX32));
  end

  // Next count: load, else step with wrap, else hold.
  always_comb begin
    o_d    = o_q;
    cout_d = 1'b0;
    if (LOAD) begin
      o_d = load_v;
    end else if (tick) begin
      if (UP) begin
        if (o_q == MAX_V) begin
          o_d    = '0;
          cout_d = 1'b1;
        end else begin
          o_d = o_q + ONE_V;
        end
      end else begin
        if (o_q == '0) begin
          o_d    = MAX_V;
          cout_d = 1'b1;
        end else begin
          o_d = o_q - ONE_V;
        end
      end
    end
  end

  // Count and wrap-pulse registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      o_q    <= '0;
      cout_q <= 1'b0;
    end else begin
      o_q    <= o_d;
      cout_q <= cout_d;
    end
  end

  assign O    = o_q;
  assign COUT = cout_q;

endmodule

// File: tb/tb_prescaled_counter.sv
// Scoreboard bench for prescaled_counter (4-bit, MAX 9, /3)
// plus a default-parameter instance for the full-width wrap.
module tb_prescaled_counter;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       CE = 1'b0;
  logic       UP = 1'b1;
  logic       LOAD = 1'b0;
  logic [3:0] DATA = '0;
  logic [3:0] O;
  logic       COUT;

  logic        rst2 = 1'b1;
  logic        ce2 = 1'b0;
  logic        up2 = 1'b1;
  logic        load2 = 1'b0;
  logic [25:0] data2 = '0;
  logic [25:0] o2;
  logic        cout2;

  int n_checks = 0;
  int n_pass   = 0;

  int exp_o_q[$];
  bit exp_c_q[$];

  int m_cnt = 0;
  int m_pc  = 0;
  bit m_cout = 1'b0;

  localparam int M_MAX = 9;
  localparam int M_PRE = 3;

  always #5 CLK = ~CLK;

  prescaled_counter #(
    .WIDTH    (4),
    .MAX      (9),
    .PRESCALE (3)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .CE    (CE),
    .UP    (UP),
    .LOAD  (LOAD),
    .DATA  (DATA),
    .O     (O),
    .COUT  (COUT)
  );

  prescaled_counter dut2 (
    .CLK   (CLK),
    .RESET (rst2),
    .CE    (ce2),
    .UP    (up2),
    .LOAD  (load2),
    .DATA  (data2),
    .O     (o2),
    .COUT  (cout2)
  );

  task automatic check(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  // Reference: count modulo MAX+1, one step per M_PRE enables.
  task automatic model_edge(
    input bit       r,
    input bit       ld,
    input bit       ce,
    input bit       up,
    input int       d
  );
    if (r) begin
      m_cnt = 0;
      m_pc = 0;
      m_cout = 0;
    end else if (ld) begin
      m_cnt = (d > M_MAX) ? M_MAX : d;
      m_pc = 0;
      m_cout = 0;
    end else begin
      m_cout = 0;
      if (ce) begin
        m_pc++;
        if (m_pc == M_PRE) begin
          m_pc = 0;
          if (up) begin
            m_cout = (m_cnt == M_MAX);
            m_cnt = (m_cnt + 1) % (M_MAX + 1);
          end else begin
            m_cout = (m_cnt == 0);
            m_cnt = (m_cnt + M_MAX) % (M_MAX + 1);
          end
        end
      end
    end
  endtask

  task automatic step(
    input bit         r,
    input bit         ld,
    input bit         ce,
    input bit         up,
    input logic [3:0] d
  );
    @(negedge CLK);
    RESET = r;
    LOAD = ld;
    CE = ce;
    UP = up;
    DATA = d;
    model_edge(r, ld, ce, up, int'(d));
    exp_o_q.push_back(m_cnt);
    exp_c_q.push_back(m_cout);
  endtask

  task automatic async_rst_pulse();
    @(negedge CLK);
    RESET = 1'b0;
    LOAD = 1'b1;
    CE = 1'b1;
    UP = 1'b1;
    DATA = 4'd5;
    #1;
    RESET = 1'b1;
    #1;
    check("async_o", 32'(O), 32'd0);
    check("async_cout", 32'(COUT), 32'd0);
    model_edge(1'b1, 1'b0, 1'b0, 1'b0, 0);
    exp_o_q.push_back(m_cnt);
    exp_c_q.push_back(m_cout);
  endtask

  // Monitor: pop one expectation per edge and compare.
  initial begin
    int eo;
    bit ec;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_o_q.size() > 0) begin
        eo = exp_o_q.pop_front();
        ec = exp_c_q.pop_front();
        check("sb_o", 32'(O), 32'(eo));
        check("sb_cout", 32'(COUT), 32'(ec));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    #2;
    check("rst_o", 32'(O), 32'd0);
    check("rst_cout", 32'(COUT), 32'd0);

    step(1, 0, 0, 1, 4'd0);
    for (int i = 0; i < 30; i++) step(0, 0, 1, 1, 4'd0);
    @(posedge CLK);
    #2;
    check("up30_o", 32'(O), 32'd0);
    check("up30_cout", 32'(COUT), 32'd1);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 4'd0);

    step(0, 1, 0, 1, 4'd1);
    for (int i = 0; i < 12; i++) step(0, 0, 1, 0, 4'd0);

    step(1, 0, 0, 1, 4'd0);
    step(0, 0, 1, 1, 4'd0);
    step(0, 0, 1, 1, 4'd0);
    step(0, 1, 1, 1, 4'd15);
    @(posedge CLK);
    #2;
    check("clamp_o", 32'(O), 32'd9);
    check("clamp_cout", 32'(COUT), 32'd0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 4'd0);

    for (int i = 0; i < 14; i++)
      step(0, 0, (i % 2) == 0, 1, 4'd0);

    step(0, 1, 0, 1, 4'd7);
    step(0, 0, 1, 1, 4'd0);
    step(0, 0, 1, 1, 4'd0);
    async_rst_pulse();
    for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 4'd0);

    for (int i = 0; i < 500; i++) begin
      step(($urandom % 60) == 0,
           ($urandom % 12) == 0,
           ($urandom % 10) < 7,
           $urandom % 2,
           4'($urandom % 16));
    end
    step(0, 0, 0, 1, 4'd0);
    repeat (3) @(posedge CLK);

    @(negedge CLK);
    rst2 = 1'b1;
    @(negedge CLK);
    rst2 = 1'b0;
    load2 = 1'b1;
    data2 = 26'h3FF_FFFE;
    @(posedge CLK);
    #1;
    check("def_load", 32'(o2), 32'h3FF_FFFE);
    @(negedge CLK);
    load2 = 1'b0;
    ce2 = 1'b1;
    @(posedge CLK);
    #1;
    check("def_max_o", 32'(o2), 32'h3FF_FFFF);
    check("def_max_cout", 32'(cout2), 32'd0);
    @(posedge CLK);
    #1;
    check("def_wrap_o", 32'(o2), 32'd0);
    check("def_wrap_cout", 32'(cout2), 32'd1);
    @(negedge CLK);
    ce2 = 1'b0;
    @(posedge CLK);
    #1;
    check("def_hold_o", 32'(o2), 32'd0);
    check("def_hold_cout", 32'(cout2), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
